// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared types and segment constants for seg_scan_ctrl
package seg_scan_ctrl_pkg;
`include "seg_defs.vh"

    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
        logic       blank;
        logic [3:0] bright;
    } slot_t;

    localparam slot_t SLOT_RESET = '{nib: 4'h0, dp: 1'b0, blank: 1'b1, bright: 4'h0};
endpackage

// File: rtl/seg_defs.vh
// rtl/seg_defs.vh - active-low seven-segment codes shared by the scan controller
`ifndef SEG_DEFS_VH
`define SEG_DEFS_VH
localparam logic [7:0] SEG_HEX_0 = 8'hC0;
localparam logic [7:0] SEG_HEX_1 = 8'hF9;
localparam logic [7:0] SEG_HEX_2 = 8'hA4;
localparam logic [7:0] SEG_HEX_3 = 8'hB0;
localparam logic [7:0] SEG_HEX_4 = 8'h99;
localparam logic [7:0] SEG_HEX_5 = 8'h92;
localparam logic [7:0] SEG_HEX_6 = 8'h82;
localparam logic [7:0] SEG_HEX_7 = 8'hF8;
localparam logic [7:0] SEG_HEX_8 = 8'h80;
localparam logic [7:0] SEG_HEX_9 = 8'h90;
localparam logic [7:0] SEG_HEX_A = 8'h88;
localparam logic [7:0] SEG_HEX_B = 8'h83;
localparam logic [7:0] SEG_HEX_C = 8'hC6;
localparam logic [7:0] SEG_HEX_D = 8'hA1;
localparam logic [7:0] SEG_HEX_E = 8'h86;
localparam logic [7:0] SEG_HEX_F = 8'h8E;
localparam logic [7:0] SEG_BLANK = 8'hFF;
`endif

// File: rtl/seg_scan_ctrl_hex7seg.sv
// rtl/seg_scan_ctrl_hex7seg.sv - combinational nibble to active-low segment decoder
module hex7seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_HEX_0;
            4'h1: o_seg = SEG_HEX_1;
            4'h2: o_seg = SEG_HEX_2;
            4'h3: o_seg = SEG_HEX_3;
            4'h4: o_seg = SEG_HEX_4;
            4'h5: o_seg = SEG_HEX_5;
            4'h6: o_seg = SEG_HEX_6;
            4'h7: o_seg = SEG_HEX_7;
            4'h8: o_seg = SEG_HEX_8;
            4'h9: o_seg = SEG_HEX_9;
            4'hA: o_seg = SEG_HEX_A;
            4'hB: o_seg = SEG_HEX_B;
            4'hC: o_seg = SEG_HEX_C;
            4'hD: o_seg = SEG_HEX_D;
            4'hE: o_seg = SEG_HEX_E;
            default: o_seg = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with PWM brightness
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SCAN_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     led_en,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int SUB   = SCAN_CYCLES / 16;
    localparam int PRE_W = $clog2(SUB);
    localparam int IDX_W = $clog2(DIGITS);

    // The slot counter is split into a prescaler and a 16-step phase so that
    // cnt/SUB is available as r_sub without a divider.
    logic [PRE_W-1:0] r_pre;
    logic [3:0]       r_sub;
    logic [IDX_W-1:0] r_idx;
    slot_t            r_slot;
    logic             r_tick;

    logic             w_pre_last;
    logic             w_boundary;
    logic             w_idx_last;
    logic [IDX_W-1:0] w_next_idx;
    logic [7:0]       w_dec;
    logic             w_on;

    assign w_pre_last = (r_pre == PRE_W'(SUB - 1));
    assign w_boundary = w_pre_last && (r_sub == 4'd15);
    assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));
    assign w_next_idx = w_idx_last ? '0 : r_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre  <= '0;
            r_sub  <= '0;
            r_idx  <= IDX_W'(DIGITS - 1);
            r_slot <= SLOT_RESET;
            r_tick <= 1'b0;
        end else if (!en) begin
            r_pre        <= '0;
            r_sub        <= '0;
            r_idx        <= IDX_W'(DIGITS - 1);
            r_slot.blank <= 1'b1;
            r_tick       <= 1'b0;
        end else begin
            r_tick <= w_boundary && w_idx_last;
            if (w_boundary) begin
                r_pre  <= '0;
                r_sub  <= '0;
                r_idx  <= w_next_idx;
                r_slot <= '{nib:    data[{w_next_idx, 2'b00} +: 4],
                            dp:     dp_in[w_next_idx],
                            blank:  blank[w_next_idx],
                            bright: bright};
            end else if (w_pre_last) begin
                r_pre <= '0;
                r_sub <= r_sub + 4'd1;
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

    hex7seg u_hex7seg (
        .i_nib (r_slot.nib),
        .o_seg (w_dec)
    );

    // en low forces blank on the next edge, so the outputs need only registered state.
    assign w_on       = !r_slot.blank && (r_sub <= r_slot.bright);
    assign led_en     = w_on ? ~(DIGITS'(1) << r_idx) : '1;
    assign seg        = w_on ? {w_dec[7] & ~r_slot.dp, w_dec[6:0]} : SEG_BLANK;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with a time-based reference model
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int SC     = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          bright;
    logic [DIGITS-1:0]   led_en;
    logic [7:0]          seg;
    logic                frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model: m_t counts cycles since counting (re)started; slot k occupies
    // cycles [32k, 32k+31] and shows digit (k-1) mod DIGITS from a snapshot
    // of the inputs taken in the last cycle of slot k-1.
    int         m_t;
    int         m_dig;
    logic [3:0] m_nib;
    logic       m_dp;
    logic       m_blank;
    logic [3:0] m_bright;
    logic       m_tick;

    seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_CYCLES(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data       (data),
        .dp_in      (dp_in),
        .blank      (blank),
        .bright     (bright),
        .led_en     (led_en),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        if (rst) begin
            m_t = 0; m_dig = DIGITS - 1; m_nib = 4'h0; m_dp = 1'b0;
            m_blank = 1'b1; m_bright = 4'h0; m_tick = 1'b0;
        end else if (!en) begin
            m_t = 0; m_dig = DIGITS - 1; m_blank = 1'b1; m_tick = 1'b0;
        end else begin
            if (m_t % SC == SC - 1) begin
                m_dig    = ((m_t + 1) / SC - 1) % DIGITS;
                m_nib    = data[4*m_dig +: 4];
                m_dp     = dp_in[m_dig];
                m_blank  = blank[m_dig];
                m_bright = bright;
                m_tick   = (m_dig == 0);
            end else begin
                m_tick = 1'b0;
            end
            m_t++;
        end
    endtask

    task automatic check_outputs();
        int                pos;
        bit                on;
        logic [DIGITS-1:0] exp_led;
        logic [7:0]        exp_seg;
        pos     = m_t % SC;
        on      = !m_blank && ((pos / (SC / 16)) <= int'(m_bright));
        exp_led = on ? ~(DIGITS'(1) << m_dig) : '1;
        exp_seg = on ? (seg_tab[m_nib] & (m_dp ? 8'h7F : 8'hFF)) : 8'hFF;
        n_cmp++;
        assert (led_en === exp_led) else begin
            n_err++;
            $error("FAIL led_en t=%0t observed=%b expected=%b", $time, led_en, exp_led);
        end
        n_cmp++;
        assert (seg === exp_seg) else begin
            n_err++;
            $error("FAIL seg t=%0t observed=%h expected=%h", $time, seg, exp_seg);
        end
        n_cmp++;
        assert (frame_tick === m_tick) else begin
            n_err++;
            $error("FAIL frame_tick t=%0t observed=%b expected=%b", $time, frame_tick, m_tick);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; data = '0; dp_in = '0; blank = '0; bright = 4'd0;
        run(3);

        en = 1'b1; data = 16'h3210; blank = 4'b0000; bright = 4'd15; rst = 1'b0;
        run(4 * SC * 2 + SC);

        bright = 4'd3; dp_in = 4'b0001;
        run(4 * SC + SC);

        blank = 4'b0100;
        run(4 * SC + SC);

        blank = 4'b0000; bright = 4'd15; dp_in = 4'b0000;
        for (int i = 0; i < 4 * SC; i++) begin
            if (m_dig == 1 && (m_t % SC) == 10) break;
            run(1);
        end
        data = 16'hFFFF;
        run(2 * SC + 8);

        data = 16'h3210;
        run(13);
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(SC + 4);
        run(21);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(SC + 4);

        for (int k = 0; k < 60; k++) begin
            data   = 16'($urandom);
            dp_in  = 4'($urandom);
            blank  = 4'($urandom) & 4'($urandom);
            bright = 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                en = 1'b0;
                run($urandom_range(1, 3));
                en = 1'b1;
            end else if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 2));
                rst = 1'b0;
            end
            run($urandom_range(1, 60));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
